// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and the CPU modules around it.
//   state_e          : multi-cycle sequencer states (IF, ID, EX, MA, WB, HALT)
//   ENABLE / DISABLE : active levels for enables driven by the sequencer
//   DEFAULT_RESET_PC : first instruction byte address after reset (word 0x80)
//   stage_onehot()   : maps a state to the {WB,MA,EX,ID,IF} one-hot stage vector
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MA   = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0200;

  // HALT (and any unused encoding) gives an all-zero stage vector.
  function automatic logic [4:0] stage_onehot(input state_e s);
    logic [4:0] v;
    v = 5'b00000;
    case (s)
      ST_IF:   v = 5'b00001;
      ST_ID:   v = 5'b00010;
      ST_EX:   v = 5'b00100;
      ST_MA:   v = 5'b01000;
      ST_WB:   v = 5'b10000;
      default: v = 5'b00000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory bus between the fetch sequencer (master) and the
// instruction memory (slave).
//   imem_addr  : byte address of the requested word
//   imem_en    : read enable, active high
//   imem_rdata : instruction word, registered inside the memory
// Handshake: there is no ready signal and no backpressure. A read is requested
// by imem_en=1 at a rising clk edge; the memory presents the word at imem_addr
// on imem_rdata from that edge onward and holds it until the next accepted read
// (or its reset preload). The sequencer relies on this 1-cycle latency.
interface fetch_sequencer_if;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;

  modport master (output imem_addr, output imem_en, input imem_rdata);
  modport slave  (input imem_addr, input imem_en, output imem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch sequencer: walks IF->ID->EX->MA->WB per
// instruction, latches the instruction word, computes the next pc (sequential
// or redirected), holds in MA on data-memory stalls and stops in HALT.
// Ports:
//   clk, nrst     : clock (rising edge), asynchronous active-low reset
//   imem          : instruction-memory bus (master side)
//   br_taken      : redirect request, used in EX only
//   br_target     : redirect byte address, used in EX only
//   mem_busy      : data-memory stall, used in MA only
//   halt_req      : stop request, used in WB only
//   pc, pc_plus4  : address of the instruction in flight and pc + 4
//   ir            : latched instruction word, valid from ID onward
//   stage         : one-hot {WB,MA,EX,ID,IF}, zero in HALT
//   halted        : in HALT
//   misalign      : sticky, a taken redirect had target[1:0] != 0
//   stall_timeout : sticky, a single MA stall reached STALL_MAX cycles
//   state_dbg     : raw FSM state
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          STALL_MAX = 16
) (
  input  logic                      clk,
  input  logic                      nrst,
  fetch_sequencer_if.master         imem,
  input  logic                      br_taken,
  input  logic [31:0]               br_target,
  input  logic                      mem_busy,
  input  logic                      halt_req,
  output logic [31:0]               pc,
  output logic [31:0]               pc_plus4,
  output logic [31:0]               ir,
  output logic [4:0]                stage,
  output logic                      halted,
  output logic                      misalign,
  output logic                      stall_timeout,
  output state_e                    state_dbg
);

  localparam int CW = $clog2(STALL_MAX + 1);
  localparam logic [CW-1:0] STALL_LIM = CW'(STALL_MAX);

  state_e        state, state_nxt;
  logic [31:0]   next_pc;
  logic [CW-1:0] stall_cnt;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_IF;
    else       state <= state_nxt;
  end

  // Next state and instruction-memory request.
  always_comb begin
    state_nxt      = state;
    imem.imem_en   = DISABLE;
    imem.imem_addr = pc;
    case (state)
      ST_IF: state_nxt = ST_ID;
      ST_ID: state_nxt = ST_EX;
      ST_EX: state_nxt = ST_MA;
      ST_MA: state_nxt = mem_busy ? ST_MA : ST_WB;
      ST_WB: begin
        if (halt_req) begin
          state_nxt = ST_HALT;
        end else begin
          state_nxt = ST_IF;
          // Fetch issued here so the word is on imem_rdata throughout IF.
          imem.imem_en   = ENABLE;
          imem.imem_addr = next_pc;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IF;
    endcase
  end

  // Registered datapath.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc            <= RESET_PC;
      next_pc       <= RESET_PC + 32'd4;
      ir            <= 32'd0;
      misalign      <= 1'b0;
      stall_timeout <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      case (state)
        ST_IF: ir <= imem.imem_rdata;
        ST_EX: begin
          next_pc <= br_taken ? {br_target[31:2], 2'b00} : pc_plus4;
          if (br_taken && (br_target[1:0] != 2'b00)) misalign <= 1'b1;
        end
        ST_MA: begin
          if (mem_busy) begin
            // Saturates at the limit; the flag is set on the edge the
            // count reaches STALL_MAX and the FSM keeps waiting.
            if (stall_cnt != STALL_LIM) begin
              stall_cnt <= stall_cnt + CW'(1);
              if (stall_cnt == STALL_LIM - CW'(1)) stall_timeout <= 1'b1;
            end
          end else begin
            stall_cnt <= '0;
          end
        end
        ST_WB: if (!halt_req) pc <= next_pc;
        default: ;
      endcase
    end
  end

  assign pc_plus4  = pc + 32'd4;
  assign stage     = stage_onehot(state);
  assign halted    = (state == ST_HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a registered instruction-memory
// model and an expected-instruction queue checked when ir becomes valid in ID.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0200;
  localparam int          SMAX   = 16;

  logic        clk;
  logic        nrst;
  logic        br_taken;
  logic [31:0] br_target;
  logic        mem_busy;
  logic        halt_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ir;
  logic [4:0]  stage;
  logic        halted;
  logic        misalign;
  logic        stall_timeout;
  state_e      state_dbg;

  fetch_sequencer_if imem ();

  fetch_sequencer #(.RESET_PC(RST_PC), .STALL_MAX(SMAX)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .imem          (imem.master),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .mem_busy      (mem_busy),
    .halt_req      (halt_req),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ir            (ir),
    .stage         (stage),
    .halted        (halted),
    .misalign      (misalign),
    .stall_timeout (stall_timeout),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory model ----------------
  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == RST_PC) return 32'h0000_0013;
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)             imem.imem_rdata <= data_of(RST_PC);
    else if (imem.imem_en) imem.imem_rdata <= data_of(imem.imem_addr);
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        exp_mis;
  logic        exp_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    br_taken  = 1'b0;
    br_target = 32'd0;
    mem_busy  = 1'b0;
    halt_req  = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(data_of(RST_PC));
    exp_pc  = RST_PC;
    exp_mis = 1'b0;
    exp_to  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stage"}, stage, 5'b00001);
    check({tag, "_pc"}, pc, RST_PC);
    check({tag, "_pc4"}, pc_plus4, RST_PC + 32'd4);
    check({tag, "_ir"}, ir, 32'd0);
    check({tag, "_halted"}, halted, 1'b0);
    check({tag, "_misalign"}, misalign, 1'b0);
    check({tag, "_timeout"}, stall_timeout, 1'b0);
    check({tag, "_en"}, imem.imem_en, 1'b0);
    check({tag, "_addr"}, imem.imem_addr, RST_PC);
  endtask

  // Runs one instruction starting in IF (called #1 or later after the edge).
  task automatic run_instr(input logic br, input logic [31:0] tgt, input int busy,
                           input logic hlt, input logic noise, input logic rst_in_ex);
    logic [31:0] nxt;
    // IF
    check("if_stage", stage, 5'b00001);
    check("if_pc", pc, exp_pc);
    check("if_pc4", pc_plus4, exp_pc + 32'd4);
    check("if_en", imem.imem_en, 1'b0);
    if (noise) begin
      br_taken = 1'b1; br_target = 32'h0000_0101; mem_busy = 1'b1; halt_req = 1'b1;
    end
    step();
    // ID
    check("id_stage", stage, 5'b00010);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL id_ir: observed %h expected none queued", ir);
    end else begin
      check("id_ir", ir, exp_q.pop_front());
    end
    step();
    // EX
    br_taken  = br;
    br_target = tgt;
    mem_busy  = noise;
    halt_req  = noise;
    check("ex_stage", stage, 5'b00100);
    if (rst_in_ex) begin
      #1 nrst = 1'b0;
      #1 check_reset_outputs("ex_rst");
      clear_inputs();
      model_reset();
      #1 nrst = 1'b1;
      return;
    end
    nxt = br ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
    if (br && (tgt[1:0] != 2'b00)) exp_mis = 1'b1;
    step();
    // MA
    br_taken  = noise;
    br_target = 32'hDEAD_BEEF;
    halt_req  = noise;
    for (int i = 0; i < busy; i++) begin
      mem_busy = 1'b1;
      check("ma_hold_stage", stage, 5'b01000);
      check("ma_hold_pc", pc, exp_pc);
      check("ma_hold_timeout", stall_timeout, exp_to | (i >= SMAX));
      step();
    end
    if (busy >= SMAX) exp_to = 1'b1;
    mem_busy = 1'b0;
    check("ma_stage", stage, 5'b01000);
    check("ma_timeout", stall_timeout, exp_to);
    check("ma_misalign", misalign, exp_mis);
    step();
    // WB
    halt_req = hlt;
    br_taken = noise;
    mem_busy = noise;
    #1;
    check("wb_stage", stage, 5'b10000);
    if (!hlt) begin
      check("wb_en", imem.imem_en, 1'b1);
      check("wb_addr", imem.imem_addr, nxt);
      exp_q.push_back(data_of(nxt));
    end else begin
      check("wb_halt_en", imem.imem_en, 1'b0);
      check("wb_halt_addr", imem.imem_addr, exp_pc);
    end
    step();
    clear_inputs();
    if (!hlt) exp_pc = nxt;
    check("post_misalign", misalign, exp_mis);
    check("post_timeout", stall_timeout, exp_to);
    if (hlt) begin
      check("halt_flag", halted, 1'b1);
      check("halt_stage", stage, 5'b00000);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    nrst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    nrst = 1'b1;

    // Sequential flow from the reset pc.
    run_instr(1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b0, 32'd0, 0, 1'b0, 1'b1, 1'b0);
    run_instr(1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0);
    check("after3_pc", pc, 32'h0000_020C);

    // Misaligned redirect, then sequential instructions keep misalign set.
    run_instr(1'b1, 32'h0000_0302, 0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b0, 32'd0, 0, 1'b0, 1'b1, 1'b0);

    // Long stall past the limit.
    run_instr(1'b0, 32'd0, 20, 1'b0, 1'b0, 1'b0);

    // Wrap at the top of the address space.
    run_instr(1'b1, 32'hFFFF_FFFC, 0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0);
    check("wrap_pc", pc, 32'h0000_0000);

    // Reset in the middle of EX.
    run_instr(1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b1);

    // Halt, stay frozen, then recover with a reset pulse.
    run_instr(1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(1'b0, 32'd0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      br_taken = 1'b1; br_target = 32'h0000_0400; mem_busy = 1'b1; halt_req = 1'b0;
      step();
      check("halt_hold_flag", halted, 1'b1);
      check("halt_hold_stage", stage, 5'b00000);
      check("halt_hold_en", imem.imem_en, 1'b0);
      check("halt_hold_pc", pc, 32'h0000_0204);
    end
    clear_inputs();
    nrst = 1'b0;
    #1 check_reset_outputs("halt_rst");
    model_reset();
    #1 nrst = 1'b1;
    run_instr(1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0200, giving the first instruction byte address (word index 0x80).
REQ-002 The block SHALL have parameter STALL_MAX, default 16, giving the maximum consecutive memory-access stall cycles before a timeout flag is raised.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, rising edge active.
REQ-004 The block SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port imem_rdata, input, 32 bits: instruction word from the instruction memory, registered in that memory with 1-cycle latency.
REQ-006 The block SHALL have port br_taken, input, 1 bit: execute-stage redirect request, sampled in EX only.
REQ-007 The block SHALL have port br_target, input, 32 bits: redirect byte address, sampled in EX only.
REQ-008 The block SHALL have port mem_busy, input, 1 bit: data-memory stall, sampled in MA only.
REQ-009 The block SHALL have port halt_req, input, 1 bit: stop request, sampled in WB only.
REQ-010 The block SHALL have port imem_addr, output, 32 bits: byte address presented to the instruction memory.
REQ-011 The block SHALL have port imem_en, output, 1 bit: instruction-memory read enable, active high.
REQ-012 The block SHALL have port pc, output, 32 bits: address of the instruction in flight.
REQ-013 The block SHALL have port pc_plus4, output, 32 bits: pc + 4.
REQ-014 The block SHALL have port ir, output, 32 bits: latched instruction.
REQ-015 The block SHALL have port stage, output, 5 bits: one-hot {WB,MA,EX,ID,IF}; all zero when HALT.
REQ-016 The block SHALL have port halted, output, 1 bit: HALT state indicator.
REQ-017 The block SHALL have port misalign, output, 1 bit: sticky flag, target[1:0] nonzero.
REQ-018 The block SHALL have port stall_timeout, output, 1 bit: sticky flag, stall exceeded STALL_MAX.

Function
REQ-019 The FSM SHALL have states IF, ID, EX, MA, WB, HALT and advance IF->ID->EX->MA->WB->IF, one cycle per state, except where REQ-023 or REQ-025 applies.
REQ-020 In IF, the FSM SHALL latch ir <= imem_rdata at the rising edge leaving IF; ir SHALL be valid from ID onward and held otherwise.
REQ-021 In EX, the FSM SHALL register next_pc <= br_taken ? {br_target[31:2],2'b00} : pc+4 (modulo 2^32, 32'hFFFF_FFFC+4 wraps to 0).
REQ-022 In EX, if br_taken=1 and br_target[1:0]!=0, the FSM SHALL set misalign, which stays set until reset.
REQ-023 In MA, while mem_busy=1 the FSM SHALL remain in MA with all registers held, and a stall counter SHALL count each held cycle; the counter SHALL clear when MA is left.
REQ-024 When the stall counter reaches STALL_MAX, the FSM SHALL set stall_timeout (sticky); it SHALL continue waiting and SHALL NOT force an exit.
REQ-025 In WB, if halt_req=1 the FSM SHALL go to HALT (terminal until reset), with pc unchanged and imem_en=0; otherwise it SHALL go to IF.
REQ-026 In WB with halt_req=0, the block SHALL drive imem_en=1 and imem_addr=next_pc combinationally, and SHALL update pc <= next_pc at the same edge, so that imem_rdata holds mem[pc] during IF.
REQ-027 In all other states, the block SHALL drive imem_en=0 and imem_addr=pc.
REQ-028 After reset, pc SHALL equal RESET_PC and the FSM SHALL be in IF, which requires the instruction memory's reset preload of word RESET_PC>>2.
REQ-029 br_taken outside EX, mem_busy outside MA, and halt_req outside WB SHALL be ignored.

Reset
REQ-030 On nrst low, at any state including mid-stall, the block SHALL immediately set: state=IF, pc=RESET_PC, next_pc=RESET_PC+4, ir=0, stage=5'b00001, halted=0, misalign=0, stall_timeout=0, stall counter=0, imem_en=0.
REQ-031 Deassertion of nrst SHALL take effect at the first rising clk edge with nrst high; no synchronizer is included in the block.

Structure
REQ-032 The state encodings, the ENABLE/DISABLE levels and the RESET_PC value SHALL live in the shared define header used by the CPU modules.
REQ-033 The block SHALL be a single module with no sub-modules; it SHALL use one state register, one next-state combinational block and one registered datapath block.

Verification
REQ-034 The bench SHALL cover reset release: release reset with imem_rdata=32'h00000013 -> first IF, pc=0x200, ir=0x13 in ID, stage walks 01,02,04,08,10.
REQ-035 The bench SHALL cover sequential flow: no redirect -> WB has imem_en=1, imem_addr=0x204; next IF pc=0x204; after 3 instructions pc=0x20C.
REQ-036 The bench SHALL cover redirect and misalign: EX br_taken=1, br_target=0x302 -> imem_addr=0x300 in WB, misalign=1, and misalign stays set after further sequential instructions.
REQ-037 The bench SHALL cover stall: mem_busy=1 for 20 MA cycles with STALL_MAX=16 -> stage=08 for 21 cycles, stall_timeout=1, pc unchanged, then WB.
REQ-038 The bench SHALL cover halt: halt_req=1 in WB -> halted=1, stage=0, imem_en=0, pc frozen for 10 cycles; nrst pulse -> IF, pc=0x200.
REQ-039 The bench SHALL cover wrap and reset mid-operation: pc=0xFFFFFFFC sequential -> next pc=0; nrst low during EX -> all outputs match REQ-030 before the next clock edge.
